// File: rtl/jogador_automatico_if.sv
// jogador_automatico_if: game-facing signals between the game and the automatic player.
interface jogador_automatico_if;
    logic [3:0] leds;
    logic       vez_jogador;
    logic [3:0] botoes;
    modport master (output leds, output vez_jogador, input botoes);
    modport slave (input leds, input vez_jogador, output botoes);
endinterface

// File: rtl/jogador_automatico.sv
// jogador_automatico: records the game's one-hot LED sequence and replays it
// as timed, one-hot button presses when the game hands the turn to the player.
module jogador_automatico #(
    parameter int HOLD_CICLOS  = 500,
    parameter int GAP_CICLOS   = 500,
    parameter int PROFUNDIDADE = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       habilita,
    jogador_automatico_if.slave        jogo,
    output logic                       ocupado,
    output logic                       concluido,
    output logic [4:0]                 num_capturadas,
    output logic                       erro_padrao,
    output logic                       erro_overflow,
    output logic [1:0]                 db_estado
);
    localparam int MAXC = (HOLD_CICLOS > GAP_CICLOS) ? HOLD_CICLOS : GAP_CICLOS;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int AW   = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;
    typedef enum logic [1:0] {OCIOSO = 2'd0, PRESSIONA = 2'd1, INTERVALO = 2'd2, CONCLUIDO = 2'd3} estado_t;
    estado_t        estado_q, estado_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [3:0]     indice_q, indice_d;
    logic [4:0]     num_q, num_d;
    logic [3:0]     botoes_q, botoes_d;
    logic [3:0]     leds_ant;
    logic           vez_ant;
    logic           erro_padrao_q, erro_padrao_d;
    logic           erro_overflow_q, erro_overflow_d;
    logic           grava;
    logic [3:0]     mem [PROFUNDIDADE];
    logic           um_quente, captura, padrao_invalido, inicio, cheio, fim_hold, fim_gap, ha_proximo;
    logic [AW-1:0]  prox;
    assign um_quente       = (jogo.leds != 4'd0) && ((jogo.leds & (jogo.leds - 4'd1)) == 4'd0);
    assign captura         = (estado_q == OCIOSO) && !jogo.vez_jogador && (leds_ant == 4'd0) && um_quente;
    assign padrao_invalido = (estado_q == OCIOSO) && (leds_ant == 4'd0) && (jogo.leds != 4'd0) && !um_quente;
    assign inicio          = (estado_q == OCIOSO) && jogo.vez_jogador && !vez_ant;
    assign cheio           = (num_q == 5'(PROFUNDIDADE));
    assign fim_hold        = (cnt_q == CW'(HOLD_CICLOS - 1));
    assign fim_gap         = (cnt_q == CW'(GAP_CICLOS - 1));
    assign ha_proximo      = ({1'b0, indice_q} + 5'd1) < num_q;
    assign prox            = indice_q[AW-1:0] + AW'(1);
    always_comb begin
        estado_d        = estado_q;
        cnt_d           = cnt_q;
        indice_d        = indice_q;
        num_d           = num_q;
        botoes_d        = botoes_q;
        erro_padrao_d   = erro_padrao_q | padrao_invalido;
        erro_overflow_d = erro_overflow_q;
        grava           = 1'b0;
        if (!habilita) begin
            estado_d = OCIOSO;
            cnt_d    = '0;
            indice_d = '0;
            num_d    = '0;
            botoes_d = '0;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    botoes_d = '0;
                    if (captura) begin
                        erro_overflow_d = erro_overflow_q | cheio;
                        grava           = !cheio;
                        num_d           = cheio ? num_q : num_q + 5'd1;
                    end
                    if (inicio) begin
                        estado_d = (num_q != 5'd0) ? PRESSIONA : CONCLUIDO;
                        cnt_d    = '0;
                        indice_d = '0;
                        botoes_d = (num_q != 5'd0) ? mem[0] : 4'd0;
                    end
                end
                PRESSIONA, INTERVALO: begin
                    // The game dropping the turn mid-playback means timeout or loss: abandon the sequence.
                    if (!jogo.vez_jogador) begin
                        estado_d = OCIOSO;
                        cnt_d    = '0;
                        indice_d = '0;
                        num_d    = '0;
                        botoes_d = '0;
                    end else if (estado_q == PRESSIONA) begin
                        estado_d = fim_hold ? INTERVALO : PRESSIONA;
                        cnt_d    = fim_hold ? '0 : cnt_q + CW'(1);
                        botoes_d = fim_hold ? 4'd0 : botoes_q;
                    end else if (fim_gap) begin
                        estado_d = ha_proximo ? PRESSIONA : CONCLUIDO;
                        cnt_d    = '0;
                        indice_d = indice_q + 4'd1;
                        botoes_d = ha_proximo ? mem[prox] : 4'd0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    botoes_d = '0;
                    if (!jogo.vez_jogador) begin
                        estado_d = OCIOSO;
                        indice_d = '0;
                        num_d    = '0;
                    end
                end
            endcase
        end
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q        <= OCIOSO;
            cnt_q           <= '0;
            indice_q        <= '0;
            num_q           <= '0;
            botoes_q        <= '0;
            leds_ant        <= '0;
            vez_ant         <= 1'b0;
            erro_padrao_q   <= 1'b0;
            erro_overflow_q <= 1'b0;
        end else begin
            estado_q        <= estado_d;
            cnt_q           <= cnt_d;
            indice_q        <= indice_d;
            num_q           <= num_d;
            botoes_q        <= botoes_d;
            leds_ant        <= jogo.leds;
            vez_ant         <= jogo.vez_jogador;
            erro_padrao_q   <= erro_padrao_d;
            erro_overflow_q <= erro_overflow_d;
        end
    end
    // Storage needs no reset: only entries below num_capturadas are ever replayed.
    always_ff @(posedge clock) begin
        if (grava) mem[num_q[AW-1:0]] <= jogo.leds;
    end
    assign jogo.botoes    = botoes_q;
    assign ocupado        = (estado_q == PRESSIONA) || (estado_q == INTERVALO);
    assign concluido      = (estado_q == CONCLUIDO);
    assign num_capturadas = num_q;
    assign erro_padrao    = erro_padrao_q;
    assign erro_overflow  = erro_overflow_q;
    assign db_estado      = estado_q;
endmodule

// File: tb/tb_jogador_automatico.sv
// tb_jogador_automatico: directed bench with a scoreboard of expected per-cycle button values.
module tb_jogador_automatico;
    localparam int HOLD = 4;
    localparam int GAP  = 3;
    logic clock = 1'b0;
    logic reset;
    logic habilita;
    logic ocupado, concluido, erro_padrao, erro_overflow;
    logic [4:0] num_capturadas;
    logic [1:0] db_estado;
    int checks = 0;
    int errors = 0;
    logic [3:0] esperado [$];
    logic [3:0] pat [16];
    jogador_automatico_if jogo ();
    jogador_automatico #(.HOLD_CICLOS(HOLD), .GAP_CICLOS(GAP), .PROFUNDIDADE(16)) dut (
        .clock(clock), .reset(reset), .habilita(habilita), .jogo(jogo),
        .ocupado(ocupado), .concluido(concluido), .num_capturadas(num_capturadas),
        .erro_padrao(erro_padrao), .erro_overflow(erro_overflow), .db_estado(db_estado)
    );
    always #5 clock = ~clock;
    task automatic tick();
        @(posedge clock);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic pulso(input logic [3:0] v);
        jogo.leds = v;
        repeat (5) tick();
        jogo.leds = 4'd0;
        tick();
    endtask
    task automatic reproduz(input int n);
        for (int i = 0; i < n; i++) begin
            repeat (HOLD) esperado.push_back(pat[i]);
            repeat (GAP) esperado.push_back(4'd0);
        end
        jogo.vez_jogador = 1'b1;
        tick();
        while (esperado.size() > 0) begin
            chk("botoes_playback", jogo.botoes, esperado.pop_front());
            tick();
        end
        chk("estado_concluido", db_estado, 2'd3);
        chk("concluido", concluido, 1'b1);
        jogo.vez_jogador = 1'b0;
        tick();
        chk("volta_ocioso", db_estado, 2'd0);
        chk("num_limpo", num_capturadas, 5'd0);
    endtask
    initial begin
        reset = 1'b1;
        habilita = 1'b1;
        jogo.leds = 4'd0;
        jogo.vez_jogador = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("reset_estado", db_estado, 2'd0);
        chk("reset_botoes", jogo.botoes, 4'd0);
        chk("reset_num", num_capturadas, 5'd0);
        chk("reset_flags", {ocupado, concluido, erro_padrao, erro_overflow}, 4'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        tick();
        // three patterns, held five cycles each, captured once apiece
        pat[0] = 4'b0001; pat[1] = 4'b0100; pat[2] = 4'b1000;
        for (int i = 0; i < 3; i++) pulso(pat[i]);
        chk("num_tres", num_capturadas, 5'd3);
        reproduz(3);
        // invalid pattern flags an error and stores nothing
        jogo.leds = 4'b0011;
        tick();
        chk("erro_padrao", erro_padrao, 1'b1);
        chk("num_sem_padrao", num_capturadas, 5'd0);
        jogo.leds = 4'd0;
        tick();
        // turn with nothing stored goes straight to done
        jogo.vez_jogador = 1'b1;
        tick();
        chk("vazio_concluido", db_estado, 2'd3);
        for (int i = 0; i < 3; i++) begin
            chk("vazio_botoes", jogo.botoes, 4'd0);
            tick();
        end
        jogo.vez_jogador = 1'b0;
        tick();
        chk("vazio_ocioso", db_estado, 2'd0);
        // seventeen pulses overflow a sixteen-entry store
        for (int i = 0; i < 17; i++) begin
            logic [3:0] v;
            v = 4'd1 << $urandom_range(0, 3);
            if (i < 16) pat[i] = v;
            pulso(v);
        end
        chk("num_cheio", num_capturadas, 5'd16);
        chk("erro_overflow", erro_overflow, 1'b1);
        reproduz(16);
        // turn lost during the second press aborts playback
        pat[0] = 4'b0010; pat[1] = 4'b0001;
        pulso(pat[0]);
        pulso(pat[1]);
        jogo.vez_jogador = 1'b1;
        tick();
        repeat (HOLD + GAP) tick();
        chk("segundo_toque", jogo.botoes, pat[1]);
        chk("ocupado", ocupado, 1'b1);
        jogo.vez_jogador = 1'b0;
        tick();
        chk("aborta_botoes", jogo.botoes, 4'd0);
        chk("aborta_estado", db_estado, 2'd0);
        chk("aborta_num", num_capturadas, 5'd0);
        // disabling mid-press forces idle and clears the store
        pulso(4'b0100);
        jogo.vez_jogador = 1'b1;
        tick();
        chk("hab_toque", jogo.botoes, 4'b0100);
        habilita = 1'b0;
        tick();
        chk("hab_botoes", jogo.botoes, 4'd0);
        chk("hab_estado", db_estado, 2'd0);
        chk("hab_num", num_capturadas, 5'd0);
        habilita = 1'b1;
        jogo.vez_jogador = 1'b0;
        tick();
        // reset between edges releases the button immediately
        pulso(4'b1000);
        jogo.vez_jogador = 1'b1;
        tick();
        tick();
        chk("pre_reset_botoes", jogo.botoes, 4'b1000);
        #2 reset = 1'b0;
        #1;
        chk("async_botoes", jogo.botoes, 4'd0);
        chk("async_estado", db_estado, 2'd0);
        chk("async_num", num_capturadas, 5'd0);
        chk("async_flags", {ocupado, concluido, erro_padrao, erro_overflow}, 4'd0);
        jogo.vez_jogador = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
